// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write integer register file for the decode
// stage. Reads are combinational with a same-cycle writeback bypass. A
// per-register load-pending scoreboard raises stall_o when decode reads a
// register whose load data has not been written back yet.
module regfile_scoreboard #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ld_issue_i,
    input  logic [ADDR_W-1:0] ld_rd_i,
    input  logic              flush_i,
    output logic              stall_o
);

    logic [DATA_W-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0] pend;
    logic [REG_NUM-1:0] pend_next;
    logic               wr_live;
    logic               hit1;
    logic               hit2;
    logic               haz1;
    logic               haz2;

    // A writeback to x0 is discarded everywhere, so qualify it once.
    assign wr_live = we_i && (waddr_i != '0);

    // Register array: clear on reset, otherwise accept writeback data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Scoreboard next state: writeback clears first, then a newer load to the
    // same register sets it again; a flush wipes everything including the
    // load issued in the flushed cycle. x0 can never be pending.
    always_comb begin
        pend_next = pend;
        if (flush_i) begin
            pend_next = '0;
        end else begin
            if (wr_live) begin
                pend_next[waddr_i] = 1'b0;
            end
            if (ld_issue_i && (ld_rd_i != '0)) begin
                pend_next[ld_rd_i] = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Read ports, bypass detection and load-use hazard; all outputs are held
    // at zero while reset is asserted.
    always_comb begin
        hit1     = we_i && (waddr_i == raddr1_i);
        hit2     = we_i && (waddr_i == raddr2_i);
        haz1     = re1_i && (raddr1_i != '0) && pend[raddr1_i] && !hit1;
        haz2     = re2_i && (raddr2_i != '0) && pend[raddr2_i] && !hit2;
        rdata1_o = '0;
        rdata2_o = '0;
        stall_o  = 1'b0;
        if (rst_n) begin
            if (re1_i && (raddr1_i != '0)) begin
                rdata1_o = hit1 ? wdata_i : regs[raddr1_i];
            end
            if (re2_i && (raddr2_i != '0)) begin
                rdata2_o = hit2 ? wdata_i : regs[raddr2_i];
            end
            stall_o = haz1 || haz2;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, a mid-run reset
// sequence, then randomized traffic against a simple array model.
module tb_regfile_scoreboard;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              re1 = 1'b0, re2 = 1'b0, we = 1'b0, ld = 1'b0, flush = 1'b0;
    logic [ADDR_W-1:0] ra1 = '0, ra2 = '0, wa = '0, ldrd = '0;
    logic [DATA_W-1:0] wd = '0;
    logic [DATA_W-1:0] rd1, rd2;
    logic              stall;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) dut (
        .clk(clk), .rst_n(rst_n),
        .re1_i(re1), .raddr1_i(ra1), .rdata1_o(rd1),
        .re2_i(re2), .raddr2_i(ra2), .rdata2_o(rd2),
        .we_i(we), .waddr_i(wa), .wdata_i(wd),
        .ld_issue_i(ld), .ld_rd_i(ldrd), .flush_i(flush),
        .stall_o(stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic              re1;
        logic [ADDR_W-1:0] ra1;
        logic              re2;
        logic [ADDR_W-1:0] ra2;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              ld;
        logic [ADDR_W-1:0] ldrd;
        logic              flush;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              es;
    } vec_t;

    vec_t vecs[19];

    // Reference model state
    logic [DATA_W-1:0]  mreg [REG_NUM];
    logic [REG_NUM-1:0] mpend;

    function automatic vec_t mk(input logic r1, input int a1, input logic r2, input int a2,
                                input logic w, input int a, input logic [31:0] d,
                                input logic l, input int lr, input logic f,
                                input logic [31:0] x1, input logic [31:0] x2, input logic xs);
        vec_t v;
        v.re1 = r1; v.ra1 = a1[ADDR_W-1:0]; v.re2 = r2; v.ra2 = a2[ADDR_W-1:0];
        v.we = w; v.wa = a[ADDR_W-1:0]; v.wd = d;
        v.ld = l; v.ldrd = lr[ADDR_W-1:0]; v.flush = f;
        v.e1 = x1; v.e2 = x2; v.es = xs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        re1 = v.re1; ra1 = v.ra1; re2 = v.re2; ra2 = v.ra2;
        we = v.we; wa = v.wa; wd = v.wd;
        ld = v.ld; ldrd = v.ldrd; flush = v.flush;
    endtask

    task automatic idle();
        re1 = 0; ra1 = '0; re2 = 0; ra2 = '0; we = 0; wa = '0; wd = '0;
        ld = 0; ldrd = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) mreg[i] = '0;
        mpend = '0;
    endtask

    function automatic logic [DATA_W-1:0] m_read(input logic r, input logic [ADDR_W-1:0] a);
        if (!r || a == 0) return '0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic m_haz(input logic r, input logic [ADDR_W-1:0] a);
        return r && a != 0 && mpend[a] && !(we && wa == a);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (we && wa != 0) mreg[wa] = wd;
        if (flush) begin
            mpend = '0;
        end else begin
            if (we && wa != 0) mpend[wa] = 1'b0;
            if (ld && ldrd != 0) mpend[ldrd] = 1'b1;
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 5, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0, 0);
        vecs[1]  = mk(1, 3, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0);
        vecs[2]  = mk(1, 3, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 1, 0, 32'h1234,     0, 0, 0, 32'h0,        32'h0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0, 0);
        vecs[5]  = mk(1, 3, 0, 0, 0, 0, 32'h0,        1, 7, 0, 32'hDEADBEEF, 32'h0, 0);
        vecs[6]  = mk(0, 0, 1, 7, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0, 1);
        vecs[7]  = mk(0, 0, 1, 7, 1, 7, 32'h55,       0, 0, 0, 32'h0,        32'h55, 0);
        vecs[8]  = mk(0, 0, 1, 7, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h55, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 9, 0, 32'h0,        32'h0, 0);
        vecs[10] = mk(1, 9, 0, 0, 1, 9, 32'hAA,       1, 9, 0, 32'hAA,       32'h0, 0);
        vecs[11] = mk(1, 9, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAA,       32'h0, 1);
        vecs[12] = mk(0, 9, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 7, 0, 32'h0,        32'h0, 0);
        vecs[14] = mk(1, 7, 0, 0, 0, 0, 32'h0,        1, 4, 1, 32'h55,       32'h0, 1);
        vecs[15] = mk(1, 7, 1, 4, 0, 0, 32'h0,        0, 0, 0, 32'h55,       32'h0, 0);
        vecs[16] = mk(1, 3, 1, 9, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'hAA, 0);
        vecs[17] = mk(1, 5, 1, 5, 1, 5, 32'h12345678, 0, 0, 0, 32'h12345678, 32'h12345678, 0);
        vecs[18] = mk(1, 5, 1, 5, 0, 0, 32'h0,        0, 0, 0, 32'h12345678, 32'h12345678, 0);

        // Reset state, held low across an edge
        idle();
        #2;
        re1 = 1; ra1 = 5'd5; re2 = 1; ra2 = 5'd5;
        #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        step();
        rst_n = 1'b1;
        idle();

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            #3;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].es});
            step();
        end

        // Mid-run asynchronous reset with a load pending and fresh data in x12
        idle();
        we = 1; wa = 5'd12; wd = 32'h77; ld = 1; ldrd = 5'd11;
        step();
        idle();
        re1 = 1; ra1 = 5'd11; re2 = 1; ra2 = 5'd12;
        #2;
        chk("prerst_stall", {31'b0, stall}, 32'h1);
        chk("prerst_rd2", rd2, 32'h77);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd2", rd2, 32'h0);
        chk("midrst_stall", {31'b0, stall}, 32'h0);
        step();
        rst_n = 1'b1;
        #2;
        chk("postrst_rd2", rd2, 32'h0);
        chk("postrst_stall", {31'b0, stall}, 32'h0);
        ra1 = 5'd3;
        #1;
        chk("postrst_x3", rd1, 32'h0);
        step();

        // Randomized traffic against the model, from a clean reset
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        step();
        for (int c = 0; c < 600; c++) begin
            re1   = $urandom_range(0, 3) != 0;
            ra1   = ADDR_W'($urandom_range(0, 7));
            re2   = $urandom_range(0, 3) != 0;
            ra2   = ADDR_W'($urandom_range(0, 7));
            we    = $urandom_range(0, 2) == 0;
            wa    = ADDR_W'($urandom_range(0, 7));
            wd    = $urandom;
            ld    = $urandom_range(0, 3) == 0;
            ldrd  = ADDR_W'($urandom_range(0, 7));
            flush = $urandom_range(0, 19) == 0;
            #3;
            chk($sformatf("rnd%0d_rd1", c), rd1, m_read(re1, ra1));
            chk($sformatf("rnd%0d_rd2", c), rd2, m_read(re2, ra2));
            chk($sformatf("rnd%0d_stall", c), {31'b0, stall},
                {31'b0, m_haz(re1, ra1) || m_haz(re2, ra2)});
            model_edge();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
